rvfi_trace_tx: RTL and testbench

- Transmit end of the RVFI trace path: captures per-instruction retirement records from rv32i_core, buffers them, and serializes each one into a framed byte packet on a valid/ready byte stream toward the host link.
- The host-side DII/trace socket consumes the stream and reconstructs RVFI records.
- Sits beside the core, fed by the core's rvfi_* retirement signals.

---
 rtl/rvfi_trace_pkg.sv | 38 +++
 rtl/rvfi_trace_fifo.sv | 68 ++++++
 rtl/rvfi_trace_tx.sv | 173 +++++++++++++++++
 tb/tb_rvfi_trace_tx.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_trace_pkg.sv
// Shared types, constants and packet builder for the RVFI trace transmit path.
package rvfi_trace_pkg;

  localparam logic [7:0]  TRACE_SYNC      = 8'hA5;
  localparam int unsigned TRACE_PKT_BYTES = 20;
  localparam int unsigned TRACE_PKT_W     = TRACE_PKT_BYTES * 8;
  localparam int unsigned TRACE_IDX_W     = 5;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] rd_wdata;
    logic [4:0]  rd_addr;
    logic        trap;
    logic        halt;
    logic [7:0]  seq;
  } trace_rec_t;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_e;

  // Lay a record out as a full packet, byte 0 in bits [7:0], checksum in the top byte.
  function automatic logic [TRACE_PKT_W-1:0] trace_pack(input trace_rec_t rec);
    logic [TRACE_PKT_W-9:0] body;
    logic [7:0]             chk;
    body = {rec.seq, rec.rd_wdata, rec.pc_wdata, rec.insn, rec.pc_rdata,
            rec.trap, rec.halt, 1'b0, rec.rd_addr, TRACE_SYNC};
    chk = '0;
    for (int unsigned i = 0; i < TRACE_PKT_BYTES - 1; i++) begin
      chk = chk ^ body[i*8 +: 8];
    end
    return {chk, body};
  endfunction

endpackage

// File: rtl/rvfi_trace_fifo.sv
// Synchronous FIFO of trace records; caller never pushes when full without popping.
module rvfi_trace_fifo
  import rvfi_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  trace_rec_t               din,
  input  logic                     pop,
  output trace_rec_t               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  trace_rec_t      mem [DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            full_q;
  logic            empty_q;

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Record storage; no reset needed, occupancy tracks validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= din;
    end
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign dout  = mem[rptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/rvfi_trace_tx.sv
// RVFI retirement capture, buffering and 20-byte framed serializer.
module rvfi_trace_tx
  import rvfi_trace_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trace_en,
  input  logic                  rvfi_valid,
  input  logic [31:0]           rvfi_insn,
  input  logic [31:0]           rvfi_pc_rdata,
  input  logic [31:0]           rvfi_pc_wdata,
  input  logic [4:0]            rvfi_rd_addr,
  input  logic [31:0]           rvfi_rd_wdata,
  input  logic                  rvfi_trap,
  input  logic                  rvfi_halt,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_last,
  output logic                  core_stall,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned LAST_IDX = TRACE_PKT_BYTES - 1;

  trace_rec_t              rec_in;
  trace_rec_t              fifo_dout;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic                    capture;
  logic                    push;
  logic                    pop;
  logic                    drop;
  logic                    load;

  logic [7:0]              seq_q;
  logic [DROP_CNT_W-1:0]   drop_cnt_q;

  tx_state_e               state_q, state_d;
  logic [TRACE_IDX_W-1:0]  idx_q, idx_d, idx_inc;
  logic [TRACE_PKT_W-1:0]  pkt_q, pkt_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_last_q, tx_last_d;

  // Incoming record; x0 writes carry no data.
  always_comb begin
    rec_in.insn     = rvfi_insn;
    rec_in.pc_rdata = rvfi_pc_rdata;
    rec_in.pc_wdata = rvfi_pc_wdata;
    rec_in.rd_wdata = (rvfi_rd_addr == 5'd0) ? 32'd0 : rvfi_rd_wdata;
    rec_in.rd_addr  = rvfi_rd_addr;
    rec_in.trap     = rvfi_trap;
    rec_in.halt     = rvfi_halt;
    rec_in.seq      = seq_q;
  end

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign capture = trace_en && rvfi_valid;
  assign push    = capture && (!fifo_full || pop);
  assign drop    = capture && fifo_full && !pop;

  rvfi_trace_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (rec_in),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sequence numbering covers dropped records; drop counter saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (capture) seq_q <= seq_q + 8'd1;
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  assign idx_inc = idx_q + TRACE_IDX_W'(1);

  // Serializer next state; a finished packet chains straight into the next record.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pkt_d      = pkt_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_last_d  = tx_last_q;
    pop        = 1'b0;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_q == TRACE_IDX_W'(LAST_IDX)) begin
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d    = IDLE;
              idx_d      = '0;
              tx_valid_d = 1'b0;
              tx_data_d  = '0;
              tx_last_d  = 1'b0;
            end
          end else begin
            idx_d     = idx_inc;
            tx_data_d = pkt_q[{idx_inc, 3'b000} +: 8];
            tx_last_d = (idx_inc == TRACE_IDX_W'(LAST_IDX));
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      pop        = 1'b1;
      pkt_d      = trace_pack(fifo_dout);
      idx_d      = '0;
      state_d    = SEND;
      tx_valid_d = 1'b1;
      tx_data_d  = TRACE_SYNC;
      tx_last_d  = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Packet register, byte index and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      pkt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_last_q  <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      pkt_q      <= pkt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_last_q  <= tx_last_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign tx_last    = tx_last_q;
  assign drop_cnt   = drop_cnt_q;
  assign core_stall = (fifo_count == CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_rvfi_trace_tx.sv
// Self-checking bench for rvfi_trace_tx: vector table, corner sequences, random vs. packet model.
module tb_rvfi_trace_tx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        trace_en, rvfi_valid;
  logic [31:0] rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_wdata;
  logic [4:0]  rvfi_rd_addr;
  logic        rvfi_trap, rvfi_halt, tx_ready;
  logic        tx_valid, tx_last, core_stall;
  logic [7:0]  tx_data;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rvfi_trace_tx #(.FIFO_DEPTH(DEPTH), .DROP_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .rvfi_valid(rvfi_valid),
    .rvfi_insn(rvfi_insn), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_trap(rvfi_trap),
    .rvfi_halt(rvfi_halt), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_last(tx_last), .core_stall(core_stall), .drop_cnt(drop_cnt)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: queue of pending packets, the packet on the wire and its next byte.
  logic [159:0] mq[$];
  bit           m_busy;
  logic [159:0] m_cur;
  int           m_idx;
  logic [7:0]   m_seq;
  int           m_drop;
  logic [8:0]   rx[$];

  function automatic logic [159:0] make_pkt(input logic [31:0] i_insn, pc, npc,
                                            input logic [4:0] rd, input logic [31:0] wd,
                                            input logic tr, hl, input logic [7:0] sq);
    logic [7:0]   b [20];
    logic [159:0] v;
    logic [31:0]  w;
    w = (rd == 5'd0) ? 32'd0 : wd;
    b[0] = 8'hA5;
    b[1] = {tr, hl, 1'b0, rd};
    for (int k = 0; k < 4; k++) begin
      b[2+k]  = pc[8*k +: 8];
      b[6+k]  = i_insn[8*k +: 8];
      b[10+k] = npc[8*k +: 8];
      b[14+k] = w[8*k +: 8];
    end
    b[18] = sq;
    b[19] = 8'h00;
    for (int k = 0; k < 19; k++) b[19] = b[19] ^ b[k];
    v = '0;
    for (int k = 0; k < 20; k++) v[8*k +: 8] = b[k];
    return v;
  endfunction

  task automatic mdl_reset();
    mq.delete();
    m_busy = 0;
    m_cur  = '0;
    m_idx  = 0;
    m_seq  = 8'd0;
    m_drop = 0;
  endtask

  // One clock of the reference: the sender frees a slot before capture is considered.
  task automatic mdl_edge();
    if (m_busy) begin
      if (tx_ready) begin
        m_idx++;
        if (m_idx == 20) begin
          if (mq.size() > 0) begin
            m_cur = mq.pop_front();
            m_idx = 0;
          end else begin
            m_busy = 0;
            m_idx  = 0;
          end
        end
      end
    end else if (mq.size() > 0) begin
      m_cur  = mq.pop_front();
      m_idx  = 0;
      m_busy = 1;
    end
    if (trace_en && rvfi_valid) begin
      if (mq.size() < DEPTH)
        mq.push_back(make_pkt(rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_addr,
                              rvfi_rd_wdata, rvfi_trap, rvfi_halt, m_seq));
      else if (m_drop < 65535)
        m_drop++;
      m_seq = m_seq + 8'd1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] ed;
    ed = m_busy ? m_cur[8*m_idx +: 8] : 8'h00;
    cmp({tag, ".valid"}, 32'(tx_valid), 32'(m_busy));
    cmp({tag, ".data"}, 32'(tx_data), 32'(ed));
    cmp({tag, ".last"}, 32'(tx_last), 32'(m_busy && (m_idx == 19)));
    cmp({tag, ".stall"}, 32'(core_stall), 32'(mq.size() == DEPTH));
    cmp({tag, ".drop"}, 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic step();
    if (tx_valid && tx_ready) rx.push_back({tx_last, tx_data});
    mdl_edge();
    @(posedge clk);
    #1;
    check_all("cyc");
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, ".valid"}, 32'(tx_valid), 0);
    cmp({tag, ".data"}, 32'(tx_data), 0);
    cmp({tag, ".last"}, 32'(tx_last), 0);
    cmp({tag, ".stall"}, 32'(core_stall), 0);
    cmp({tag, ".drop"}, 32'(drop_cnt), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check_zero("reset");
    mdl_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx.delete();
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while ((m_busy || mq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    cmp({name, ".drained"}, 32'(n < budget), 1);
  endtask

  typedef struct {
    logic [31:0] insn, pc, npc;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        trap, halt;
    logic [7:0]  exp_b1;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] lit [20];

  task automatic set_rec(input vec_t v);
    rvfi_insn     = v.insn;
    rvfi_pc_rdata = v.pc;
    rvfi_pc_wdata = v.npc;
    rvfi_rd_addr  = v.rd;
    rvfi_rd_wdata = v.wd;
    rvfi_trap     = v.trap;
    rvfi_halt     = v.halt;
  endtask

  task automatic capture_one(input vec_t v);
    set_rec(v);
    rvfi_valid = 1'b1;
    step();
    rvfi_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, run, maxrun, xr, nl;
    logic pv, pr, pl;
    logic [7:0] pd;

    vecs[0] = '{32'h00500093, 32'h80000000, 32'h80000004, 5'd1,  32'h00000005, 1'b0, 1'b0, 8'h01, 32'h00000005};
    vecs[1] = '{32'h00000013, 32'h80000010, 32'h80000014, 5'd0,  32'hDEADBEEF, 1'b0, 1'b0, 8'h00, 32'h00000000};
    vecs[2] = '{32'h12345678, 32'h00001000, 32'h00000200, 5'd31, 32'h12345678, 1'b1, 1'b0, 8'h9F, 32'h12345678};
    vecs[3] = '{32'h00100073, 32'hFFFFFFFC, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b1, 8'h40, 32'h00000000};
    vecs[4] = '{32'hCAFEF00D, 32'h8000ABCD, 32'h8000ABD1, 5'd10, 32'hCAFEF00D, 1'b1, 1'b1, 8'hCA, 32'hCAFEF00D};
    lit = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h93, 8'h00, 8'h50, 8'h00,
            8'h04, 8'h00, 8'h00, 8'h80, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h66};

    trace_en = 1'b1; rvfi_valid = 1'b0; tx_ready = 1'b1;
    rvfi_insn = '0; rvfi_pc_rdata = '0; rvfi_pc_wdata = '0;
    rvfi_rd_addr = '0; rvfi_rd_wdata = '0; rvfi_trap = 1'b0; rvfi_halt = 1'b0;
    #1;
    do_reset();

    // Table: one isolated record each, ready held high.
    for (int i = 0; i < 5; i++) begin
      rx.delete();
      capture_one(vecs[i]);
      cmp($sformatf("vec%0d.lat_idle", i), 32'(tx_valid), 0);
      step();
      cmp($sformatf("vec%0d.lat_b0v", i), 32'(tx_valid), 1);
      cmp($sformatf("vec%0d.lat_b0d", i), 32'(tx_data), 32'hA5);
      drain(60, $sformatf("vec%0d", i));
      cmp($sformatf("vec%0d.len", i), 32'(rx.size()), 20);
      cmp($sformatf("vec%0d.b1", i), 32'(rx[1][7:0]), 32'(vecs[i].exp_b1));
      for (int k = 0; k < 4; k++)
        cmp($sformatf("vec%0d.wd%0d", i, k), 32'(rx[14+k][7:0]), 32'(vecs[i].exp_wd[8*k +: 8]));
      cmp($sformatf("vec%0d.seq", i), 32'(rx[18][7:0]), i);
      xr = 0; nl = 0;
      foreach (rx[k]) begin
        xr = xr ^ int'(rx[k][7:0]);
        if (rx[k][8]) nl++;
      end
      cmp($sformatf("vec%0d.chk", i), 32'(xr), 0);
      cmp($sformatf("vec%0d.nlast", i), 32'(nl), 1);
      cmp($sformatf("vec%0d.last19", i), 32'(rx[19][8]), 1);
      if (i == 0)
        for (int k = 0; k < 20; k++)
          cmp($sformatf("vec0.byte%0d", k), 32'(rx[k][7:0]), 32'(lit[k]));
    end

    // Back-pressure: ready toggles every cycle, unaccepted bytes must hold.
    do_reset();
    capture_one(vecs[0]);
    n = 0;
    while ((m_busy || mq.size() != 0) && n < 200) begin
      tx_ready = n[0];
      pv = tx_valid; pr = tx_ready; pd = tx_data; pl = tx_last;
      step();
      if (pv && !pr) begin
        cmp("bp.hold_valid", 32'(tx_valid), 1);
        cmp("bp.hold_data", 32'(tx_data), 32'(pd));
        cmp("bp.hold_last", 32'(tx_last), 32'(pl));
      end
      n++;
    end
    cmp("bp.drained", 32'(n < 200), 1);
    cmp("bp.len", 32'(rx.size()), 20);
    for (int k = 0; k < 20; k++)
      cmp($sformatf("bp.byte%0d", k), 32'(rx[k][7:0]), 32'(lit[k]));
    tx_ready = 1'b1;

    // Overflow: six retirements against a stalled sink.
    do_reset();
    tx_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      vecs[4].insn = 32'h1000 + 32'(k);
      capture_one(vecs[4]);
      if (k == 3) cmp("ovf.stall4", 32'(core_stall), 0);
      if (k == 4) begin
        cmp("ovf.stall5", 32'(core_stall), 1);
        cmp("ovf.drop5", 32'(drop_cnt), 0);
      end
      if (k == 5) begin
        cmp("ovf.stall6", 32'(core_stall), 1);
        cmp("ovf.drop6", 32'(drop_cnt), 1);
      end
    end
    tx_ready = 1'b1;
    drain(300, "ovf");
    cmp("ovf.len", 32'(rx.size()), 100);
    for (int k = 0; k < 5; k++)
      cmp($sformatf("ovf.seq%0d", k), 32'(rx[20*k+18][7:0]), k);
    cmp("ovf.drop_end", 32'(drop_cnt), 1);

    // Back-to-back: three queued records stream with no bubble.
    do_reset();
    run = 0; maxrun = 0;
    for (int c = 0; c < 100; c++) begin
      if (c < 3) begin
        set_rec(vecs[c]);
        rvfi_valid = 1'b1;
      end else begin
        rvfi_valid = 1'b0;
      end
      step();
      if (tx_valid) run++; else run = 0;
      if (run > maxrun) maxrun = run;
    end
    cmp("b2b.run", 32'(maxrun), 60);
    cmp("b2b.len", 32'(rx.size()), 60);
    for (int k = 0; k < 3; k++)
      cmp($sformatf("b2b.seq%0d", k), 32'(rx[20*k+18][7:0]), k);

    // Async reset in the middle of a packet.
    do_reset();
    capture_one(vecs[0]);
    capture_one(vecs[2]);
    n = 0;
    while (rx.size() < 7 && n < 50) begin
      step();
      n++;
    end
    cmp("arst.reach7", 32'(rx.size()), 7);
    cmp("arst.pre_valid", 32'(tx_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("arst");
    mdl_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("arst_rel");
    rx.delete();
    capture_one(vecs[2]);
    drain(60, "arst");
    cmp("arst.len", 32'(rx.size()), 20);
    cmp("arst.seq", 32'(rx[18][7:0]), 0);
    cmp("arst.b1", 32'(rx[1][7:0]), 32'h9F);

    // Random traffic in phases of varying retire and sink rates.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int pv_pct, pr_pct;
      pv_pct = (c / 500) % 2 == 0 ? 70 : 25;
      pr_pct = (c / 300) % 3 == 0 ? 30 : 90;
      trace_en      = ($urandom_range(0, 9) != 0);
      rvfi_valid    = ($urandom_range(0, 99) < pv_pct);
      tx_ready      = ($urandom_range(0, 99) < pr_pct);
      rvfi_insn     = $urandom;
      rvfi_pc_rdata = $urandom;
      rvfi_pc_wdata = $urandom;
      rvfi_rd_wdata = $urandom;
      rvfi_rd_addr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rvfi_trap     = 1'($urandom_range(0, 1));
      rvfi_halt     = 1'($urandom_range(0, 1));
      step();
    end
    rvfi_valid = 1'b0;
    tx_ready = 1'b1;
    drain(500, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
